// File: rtl/gpio_dig_ctrl_pkg.sv
// Shared constants for the GPIO digital-test controller: widths, state encoding,
// default settings-bus addresses and register field positions.
package gpio_dig_ctrl_pkg;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned GPIO_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DIG_W  = 2 * NUM_CH;

  localparam logic [ADDR_W-1:0] CTRL_ADDR_DEF = 7'd48;
  localparam logic [ADDR_W-1:0] GPIO_ADDR_DEF = 7'd49;

  localparam int unsigned CTRL_MASK_LSB  = 0;
  localparam int unsigned CTRL_MASK_MSB  = 1;
  localparam int unsigned CTRL_DELAY_LSB = 4;
  localparam int unsigned CTRL_DELAY_MSB = 7;
  localparam int unsigned GPIO_HOST_LSB  = 0;
  localparam int unsigned GPIO_HOST_MSB  = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Expand a per-channel mask to the {q,i} bit pair of each channel.
  function automatic logic [DIG_W-1:0] ch_bits(input logic [NUM_CH-1:0] mask);
    return {{2{mask[1]}}, {2{mask[0]}}};
  endfunction

endpackage

// File: rtl/gpio_dig_ctrl_if.sv
// Settings bus, TX strobe, digital chain LSBs and pin outputs of gpio_dig_ctrl.
interface gpio_dig_ctrl_if;
  import gpio_dig_ctrl_pkg::*;

  logic                strobe;
  logic                serial_strobe;
  logic [ADDR_W-1:0]   serial_addr;
  logic [DATA_W-1:0]   serial_data;
  logic [NUM_CH-1:0]   i_dig;
  logic [NUM_CH-1:0]   q_dig;
  logic [NUM_CH-1:0]   enable_dig;
  logic [GPIO_W-1:0]   gpio_out;
  logic                dig_active;
  logic [1:0]          state_o;

  modport slave (
    input  strobe, serial_strobe, serial_addr, serial_data, i_dig, q_dig,
    output enable_dig, gpio_out, dig_active, state_o
  );

  modport master (
    output strobe, serial_strobe, serial_addr, serial_data, i_dig, q_dig,
    input  enable_dig, gpio_out, dig_active, state_o
  );

endinterface

// File: rtl/gpio_dig_ctrl_regs.sv
// Settings-bus decode: control register (request mask, delay) and static host GPIO value.
module gpio_dig_ctrl_regs
  import gpio_dig_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CTRL_ADDR = CTRL_ADDR_DEF,
  parameter logic [ADDR_W-1:0] GPIO_ADDR = GPIO_ADDR_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              serial_strobe_i,
  input  logic [ADDR_W-1:0] serial_addr_i,
  input  logic [DATA_W-1:0] serial_data_i,
  output logic [NUM_CH-1:0] req_mask_o,
  output logic [CNT_W-1:0]  delay_o,
  output logic [GPIO_W-1:0] host_gpio_o
);

  logic [NUM_CH-1:0] req_mask_q;
  logic [CNT_W-1:0]  delay_q;
  logic [GPIO_W-1:0] host_gpio_q;
  logic              ctrl_we;
  logic              gpio_we;
  logic              unused_data;

  assign ctrl_we     = serial_strobe_i && (serial_addr_i == CTRL_ADDR);
  assign gpio_we     = serial_strobe_i && (serial_addr_i == GPIO_ADDR);
  assign unused_data = ^serial_data_i[DATA_W-1:GPIO_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_mask_q  <= '0;
      delay_q     <= '0;
      host_gpio_q <= '0;
    end else begin
      if (ctrl_we) begin
        req_mask_q <= serial_data_i[CTRL_MASK_MSB:CTRL_MASK_LSB];
        delay_q    <= serial_data_i[CTRL_DELAY_MSB:CTRL_DELAY_LSB];
      end
      if (gpio_we) begin
        host_gpio_q <= serial_data_i[GPIO_HOST_MSB:GPIO_HOST_LSB];
      end
    end
  end

  assign req_mask_o  = req_mask_q;
  assign delay_o     = delay_q;
  assign host_gpio_o = host_gpio_q;

endmodule

// File: rtl/gpio_dig_ctrl.sv
// GPIO digital-test controller: sequences the TX digital chains through
// IDLE/ARM/RUN/DRAIN and muxes their captured LSBs onto the low GPIO pins.
module gpio_dig_ctrl
  import gpio_dig_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CTRL_ADDR = CTRL_ADDR_DEF,
  parameter logic [ADDR_W-1:0] GPIO_ADDR = GPIO_ADDR_DEF
) (
  input  logic           clock,
  input  logic           reset,
  gpio_dig_ctrl_if.slave bus
);

  logic [NUM_CH-1:0] req_mask;
  logic [CNT_W-1:0]  delay;
  logic [GPIO_W-1:0] host_gpio;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] act_q, act_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIG_W-1:0]  dig_q, dig_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic              dact_q, dact_d;
  logic [DIG_W-1:0]  dig_sample;
  logic [DIG_W-1:0]  dig_sel;

  gpio_dig_ctrl_regs #(
    .CTRL_ADDR (CTRL_ADDR),
    .GPIO_ADDR (GPIO_ADDR)
  ) u_regs (
    .clock           (clock),
    .reset           (reset),
    .serial_strobe_i (bus.serial_strobe),
    .serial_addr_i   (bus.serial_addr),
    .serial_data_i   (bus.serial_data),
    .req_mask_o      (req_mask),
    .delay_o         (delay),
    .host_gpio_o     (host_gpio)
  );

  assign dig_sample = {bus.q_dig[1], bus.i_dig[1], bus.q_dig[0], bus.i_dig[0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      act_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      en_q    <= '0;
      gpio_q  <= '0;
      dact_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      en_q    <= en_d;
      gpio_q  <= gpio_d;
      dact_q  <= dact_d;
    end
  end

  // ARM reacts to mask rewrites immediately; every other transition waits for a strobe.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.strobe && (req_mask != '0)) begin
          act_d   = req_mask;
          cnt_d   = delay;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (req_mask == '0) begin
          state_d = ST_IDLE;
        end else if (req_mask != act_q) begin
          act_d = req_mask;
          cnt_d = delay;
        end else if (bus.strobe) begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.strobe) begin
          dig_d = dig_sample & ch_bits(act_q);
          if (req_mask != act_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.strobe) begin
          if (req_mask != '0) begin
            act_d   = req_mask;
            cnt_d   = delay;
            state_d = ST_ARM;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the current state one clock later.
  always_comb begin
    en_d    = '0;
    dact_d  = 1'b0;
    dig_sel = host_gpio[DIG_W-1:0];
    if (state_q == ST_RUN) begin
      en_d   = act_q;
      dact_d = 1'b1;
    end
    if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
      dig_sel = (dig_q & ch_bits(act_q)) | (host_gpio[DIG_W-1:0] & ~ch_bits(act_q));
    end
    gpio_d = {host_gpio[GPIO_W-1:DIG_W], dig_sel};
  end

  assign bus.enable_dig = en_q;
  assign bus.gpio_out   = gpio_q;
  assign bus.dig_active = dact_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_gpio_dig_ctrl.sv
// Self-checking bench for gpio_dig_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_gpio_dig_ctrl;

  localparam int S_IDLE = 0, S_ARM = 1, S_RUN = 2, S_DRAIN = 3;
  localparam logic [6:0] A_CTRL = 7'd48, A_GPIO = 7'd49;

  logic clock = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  gpio_dig_ctrl_if ifc ();

  gpio_dig_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  // Behavioural model state
  int         m_state, m_cnt, m_delay;
  logic [1:0] m_req, m_act;
  logic [1:0] m_chan [2];
  logic [15:0] m_host;
  logic [1:0] m_en;
  logic [15:0] m_gpio;
  logic       m_dact;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_cnt = 0; m_delay = 0;
    m_req = 2'b00; m_act = 2'b00; m_host = 16'h0;
    m_chan[0] = 2'b00; m_chan[1] = 2'b00;
    m_en = 2'b00; m_gpio = 16'h0; m_dact = 1'b0;
  endtask

  // One clock of the controller, computed from the pre-edge model state and inputs.
  task automatic model_step();
    int          ns, nc;
    logic [1:0]  na;
    logic [1:0]  nch [2];
    logic [15:0] ng;
    ng = m_host;
    for (int ch = 0; ch < 2; ch++)
      if ((m_state == S_RUN || m_state == S_DRAIN) && m_act[ch]) ng[2*ch +: 2] = m_chan[ch];
    m_en   = (m_state == S_RUN) ? m_act : 2'b00;
    m_dact = (m_state == S_RUN);
    ns = m_state; nc = m_cnt; na = m_act; nch = m_chan;
    case (m_state)
      S_IDLE:
        if (ifc.strobe && m_req != 2'b00) begin ns = S_ARM; na = m_req; nc = m_delay; end
      S_ARM:
        if (m_req == 2'b00) ns = S_IDLE;
        else if (m_req != m_act) begin na = m_req; nc = m_delay; end
        else if (ifc.strobe) begin
          if (m_cnt == 0) ns = S_RUN;
          else nc = m_cnt - 1;
        end
      S_RUN:
        if (ifc.strobe) begin
          for (int ch = 0; ch < 2; ch++)
            nch[ch] = m_act[ch] ? {ifc.q_dig[ch], ifc.i_dig[ch]} : 2'b00;
          if (m_req != m_act) ns = S_DRAIN;
        end
      default:
        if (ifc.strobe) begin
          if (m_req != 2'b00) begin ns = S_ARM; na = m_req; nc = m_delay; end
          else ns = S_IDLE;
        end
    endcase
    if (ifc.serial_strobe && ifc.serial_addr == A_CTRL) begin
      m_req   = ifc.serial_data[1:0];
      m_delay = int'(ifc.serial_data[7:4]);
    end
    if (ifc.serial_strobe && ifc.serial_addr == A_GPIO) m_host = ifc.serial_data[15:0];
    m_state = ns; m_cnt = nc; m_act = na; m_chan = nch; m_gpio = ng;
  endtask

  task automatic compare_all();
    chk("state_o",    32'(ifc.state_o),    32'(m_state));
    chk("enable_dig", 32'(ifc.enable_dig), 32'(m_en));
    chk("gpio_out",   32'(ifc.gpio_out),   32'(m_gpio));
    chk("dig_active", 32'(ifc.dig_active), 32'(m_dact));
  endtask

  task automatic cyc(input logic stb, input logic ss, input logic [6:0] a, input logic [31:0] d);
    ifc.strobe = stb; ifc.serial_strobe = ss; ifc.serial_addr = a; ifc.serial_data = d;
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 7'd0, 32'd0);
  endtask

  task automatic stb1();
    cyc(1'b1, 1'b0, 7'd0, 32'd0);
  endtask

  task automatic wr_ctrl(input logic [1:0] mask, input logic [3:0] dly);
    cyc(1'b0, 1'b1, A_CTRL, {24'd0, dly, 2'b00, mask});
  endtask

  task automatic wr_gpio(input logic [15:0] v);
    cyc(1'b0, 1'b1, A_GPIO, {16'd0, v});
  endtask

  initial begin
    logic [31:0] d;
    logic [6:0]  a;
    reset = 1'b1;
    ifc.strobe = 1'b0; ifc.serial_strobe = 1'b0; ifc.serial_addr = '0;
    ifc.serial_data = '0; ifc.i_dig = '0; ifc.q_dig = '0;
    model_reset();
    #12;
    chk("rst_state", 32'(ifc.state_o), 32'd0);
    chk("rst_gpio",  32'(ifc.gpio_out), 32'd0);
    chk("rst_en",    32'(ifc.enable_dig), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Start-up: host GPIO drives the pins
    wr_gpio(16'hA5A5);
    wr_ctrl(2'b00, 4'd0);
    chk("start_gpio", 32'(ifc.gpio_out), 32'hA5A5);
    chk("start_en",   32'(ifc.enable_dig), 32'd0);

    // Channel 0 with delay 3, strobe every 4 clocks
    ifc.i_dig = 2'b01; ifc.q_dig = 2'b00;
    wr_ctrl(2'b01, 4'd3);
    idle(1);
    for (int s = 1; s <= 5; s++) begin
      stb1();
      if (s == 1) chk("arm_after_1st", 32'(ifc.state_o), 32'd1);
      if (s == 4) chk("arm_after_4th", 32'(ifc.state_o), 32'd1);
      if (s == 5) begin
        chk("run_after_5th", 32'(ifc.state_o), 32'd2);
        chk("en_lag", 32'(ifc.enable_dig), 32'd0);
      end
      if (s < 5) idle(3);
    end
    idle(1);
    chk("en_run", 32'(ifc.enable_dig), 32'd1);
    stb1(); idle(1);
    chk("dig_i1", 32'(ifc.gpio_out[3:0]), 32'h5);
    ifc.i_dig = 2'b00;
    stb1(); idle(1);
    chk("dig_i0", 32'(ifc.gpio_out[3:0]), 32'h4);
    chk("hi_host", 32'(ifc.gpio_out[15:4]), 32'hA5A);

    // Move to both channels, then shut down
    wr_ctrl(2'b11, 4'd0);
    stb1(); stb1(); stb1();
    chk("run_11", 32'(ifc.state_o), 32'd2);
    ifc.i_dig = 2'b11; ifc.q_dig = 2'b10;
    stb1(); idle(1);
    chk("dig_11", 32'(ifc.gpio_out[3:0]), 32'hD);
    wr_ctrl(2'b00, 4'd0);
    stb1();
    chk("drain", 32'(ifc.state_o), 32'd3);
    ifc.i_dig = 2'b00; ifc.q_dig = 2'b00;
    idle(2);
    chk("drain_en", 32'(ifc.enable_dig), 32'd0);
    chk("drain_hold", 32'(ifc.gpio_out[3:0]), 32'hD);
    stb1();
    chk("drain_idle", 32'(ifc.state_o), 32'd0);
    idle(1);
    chk("idle_host", 32'(ifc.gpio_out[3:0]), 32'h5);

    // Cancel during ARM
    wr_ctrl(2'b01, 4'd15);
    stb1();
    chk("arm15", 32'(ifc.state_o), 32'd1);
    idle(2);
    wr_ctrl(2'b00, 4'd0);
    idle(1);
    chk("cancel_idle", 32'(ifc.state_o), 32'd0);
    idle(2);
    chk("cancel_en", 32'(ifc.enable_dig), 32'd0);

    // Write/strobe collision in RUN
    wr_ctrl(2'b01, 4'd0);
    stb1(); stb1();
    ifc.i_dig = 2'b11; ifc.q_dig = 2'b11;
    idle(1);
    cyc(1'b1, 1'b1, A_CTRL, 32'h0000_0002);
    chk("coll_state", 32'(ifc.state_o), 32'd2);
    idle(1);
    chk("coll_dig", 32'(ifc.gpio_out[3:0]), 32'h7);
    stb1();
    chk("coll_drain", 32'(ifc.state_o), 32'd3);
    stb1();
    chk("coll_arm", 32'(ifc.state_o), 32'd1);
    stb1(); idle(1);
    chk("coll_en10", 32'(ifc.enable_dig), 32'd2);

    // Reset mid-RUN
    stb1(); idle(1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_en",   32'(ifc.enable_dig), 32'd0);
    chk("mid_rst_gpio", 32'(ifc.gpio_out), 32'd0);
    chk("mid_rst_act",  32'(ifc.dig_active), 32'd0);
    chk("mid_rst_st",   32'(ifc.state_o), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    idle(1);
    chk("post_rst_st", 32'(ifc.state_o), 32'd0);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      ifc.i_dig = 2'($urandom); ifc.q_dig = 2'($urandom);
      d = $urandom;
      case ($urandom_range(0, 2))
        0: a = A_CTRL;
        1: a = A_GPIO;
        default: a = 7'($urandom);
      endcase
      if (a == A_CTRL) d[7:4] = 4'($urandom_range(0, 3));
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_dig_ctrl.md
GPIO_DIG_CTRL -- requirements
Module: gpio_dig_ctrl

Interface
REQ-001 Parameter CTRL_ADDR, default 7'd48: settings-bus address of the control register.
REQ-002 Parameter GPIO_ADDR, default 7'd49: settings-bus address of the static host GPIO register.
REQ-003 clock  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 strobe  in  1  TX sample strobe, one clock wide.
REQ-006 serial_strobe  in  1  settings write qualifier.
REQ-007 serial_addr  in  7  settings address.
REQ-008 serial_data  in  32  settings data.
REQ-009 i_dig / q_dig  in  2 each  per-channel digital LSBs from the two TX digital chains; index = channel.
REQ-010 enable_dig  out  2  per-channel enable to the TX digital chains.
REQ-011 gpio_out  out  16  pin values.
REQ-012 dig_active  out  1  high only in RUN.
REQ-013 state_o  out  2  FSM state: IDLE=0, ARM=1, RUN=2, DRAIN=3.

Function
REQ-014 Control register fields: [1:0] req_mask (per-channel request); [7:4] delay, 0..15 strobes.
REQ-015 GPIO register field: [15:0] host_gpio (static pin value).
REQ-016 A write with serial_strobe=1 and a matching address updates the register on that edge; the new value is first used on the following cycle.
REQ-017 A strobe coinciding with a write is processed against the old register values.
REQ-018 State transitions happen only on strobe cycles, except REQ-021 and REQ-022.
REQ-019 IDLE: on strobe with req_mask!=0, latch active_mask=req_mask, load cnt=delay, go to ARM.
REQ-020 ARM, on strobe:
- if cnt==0, go to RUN;
- otherwise decrement cnt.
- delay=0 therefore reaches RUN on the first strobe after entering ARM.
REQ-021 ARM: a write setting req_mask=0 returns to IDLE on the next cycle, without waiting for a strobe.
REQ-022 ARM: a write of a different nonzero req_mask relatches active_mask and reloads cnt from the new delay on the next cycle.
REQ-023 RUN:
- enable_dig=active_mask (registered; asserted the cycle after entering RUN);
- on each strobe, capture dig_reg={q_dig[1],i_dig[1],q_dig[0],i_dig[0]}, masked per channel by active_mask.
REQ-024 RUN, on strobe with req_mask!=active_mask: go to DRAIN and clear enable_dig.
REQ-025 DRAIN:
- hold dig_reg unchanged for exactly one strobe;
- on that strobe, if req_mask!=0 go to ARM (relatch, reload), else go to IDLE.
REQ-026 gpio_out[15:4]=host_gpio[15:4] at all times.
REQ-027 gpio_out[3:0]:
- dig_reg bits of channels in active_mask while in RUN or DRAIN;
- otherwise host_gpio[3:0].
- gpio_out is registered, one clock behind its source.
REQ-028 enable_dig is 0 in IDLE, ARM and DRAIN.
REQ-029 dig_active=(state==RUN), registered.
REQ-030 Strobes in IDLE with req_mask=0 have no effect.

Reset
REQ-031 On reset, asynchronously and immediately:
- state=IDLE, req_mask=0, delay=0, host_gpio=0, active_mask=0, cnt=0, dig_reg=0;
- enable_dig=0, gpio_out=0, dig_active=0, state_o=0.
REQ-032 Reset in RUN or DRAIN abandons the drain; outputs show reset values during and after reset until new writes.

Structure
REQ-033 A shared package holds:
- the state encoding constants;
- default CTRL_ADDR/GPIO_ADDR;
- control-field bit positions.
REQ-034 Settings-register decode is one sub-module, gpio_dig_ctrl_regs; the FSM and output mux stay in the top.

Verification
REQ-035 Start: write GPIO=16'hA5A5, CTRL=0. Response: gpio_out=16'hA5A5 two clocks after the write; enable_dig=0.
REQ-036 Start-up sequence:
- stimulus: CTRL mask=2'b01, delay=3; strobe every 4 clocks;
- response: ARM after 1st strobe; RUN after 5th strobe; enable_dig=2'b01 one clock later;
- i_dig[0]=1 gives gpio_out[0]=1, with gpio_out[3:1] still from host_gpio.
REQ-037 Shutdown:
- stimulus: in RUN with mask 2'b11, write mask=0;
- response: DRAIN on next strobe, enable_dig=0;
- gpio_out[3:0] holds last dig_reg for one strobe, then IDLE and host_gpio[3:0].
REQ-038 Cancel during ARM:
- stimulus: in ARM with delay=15, write mask=0 between strobes;
- response: IDLE one clock later; no enable_dig pulse.
REQ-039 Write/strobe collision:
- stimulus: write mask=2'b10 on the same cycle as a strobe in RUN with mask 2'b01;
- response: that strobe captures with mask 01; DRAIN on the next strobe; then ARM with mask 10.
REQ-040 Reset mid-operation:
- stimulus: assert reset mid-RUN;
- response: all outputs 0 within the reset cycle; state_o=0 after release.
